imem_loader: RTL and testbench

- Writer side of the 64-word instruction memory that the fetch path reads through a 6-bit word address.
- Accepts a byte stream over a valid/ready handshake, e.g. from a UART receiver or debug port.
- Assembles each group of four bytes into a 32-bit big-endian word and writes it to consecutive word addresses starting at 0.
- Asserts busy while loading so the core can be held in reset or stalled until the program image is in place.

---
 rtl/imem_loader_if.sv | 23 ++
 rtl/imem_loader.sv | 119 +++++++++++
 tb/tb_imem_loader.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the imem loader.
// The slave modport is the loader side; the master modport is the byte source and memory side.
interface imem_loader_if #(
  parameter int ADDR_W = 6,
  parameter int WORD_W = 32
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WORD_W-1:0] wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, we, waddr, wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, we, waddr, wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Loads big-endian 32-bit words from a byte stream into consecutive instruction-memory
// addresses starting at 0.
//   state | meaning
//   IDLE  | waiting for start; the byte stream is not accepted
//   RECV  | collecting the four bytes of the current word
//   WRITE | one-cycle write of the assembled word
//   DONE  | one-cycle done pulse after a complete load
module imem_loader #(
  parameter int ADDR_W = 6,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic              abort,
  imem_loader_if.slave      bus,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count
);
  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state;
  logic [1:0]        byte_cnt;
  logic [WORD_W-1:0] shift_reg;
  logic [ADDR_W:0]   word_idx;
  logic [ADDR_W:0]   load_len;
  logic [ADDR_W:0]   idx_next;
  logic              accept;

  assign accept   = bus.byte_valid & bus.byte_ready;
  assign idx_next = word_idx + ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      bus.we         <= 1'b0;
      bus.waddr      <= '0;
      bus.wdata      <= '0;
      bus.byte_ready <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      word_count     <= '0;
      byte_cnt       <= '0;
      shift_reg      <= '0;
      word_idx       <= '0;
      load_len       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            word_count <= '0;
            word_idx   <= '0;
            byte_cnt   <= '0;
            if (num_words == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state          <= RECV;
              busy           <= 1'b1;
              bus.byte_ready <= 1'b1;
              // Clamping the length is what keeps the address from wrapping.
              load_len       <= (num_words > DEPTH) ? DEPTH : num_words;
            end
          end
        end

        RECV: begin
          if (abort) begin
            state          <= IDLE;
            busy           <= 1'b0;
            bus.byte_ready <= 1'b0;
            byte_cnt       <= '0;
          end else if (accept) begin
            shift_reg <= {shift_reg[WORD_W-9:0], bus.byte_data};
            byte_cnt  <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state          <= WRITE;
              bus.byte_ready <= 1'b0;
              bus.we         <= 1'b1;
              bus.waddr      <= word_idx[ADDR_W-1:0];
              bus.wdata      <= {shift_reg[WORD_W-9:0], bus.byte_data};
            end
          end
        end

        WRITE: begin
          bus.we     <= 1'b0;
          word_idx   <= idx_next;
          word_count <= word_count + ONE;
          byte_cnt   <= '0;
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (idx_next == load_len) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state          <= RECV;
            bus.byte_ready <= 1'b1;
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: reset, normal, zero/oversize, abort, throttled and
// reset-mid-load cases with hand-computed expected words.
module tb_imem_loader;
  localparam int ADDR_W = 6;
  localparam int WORD_W = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [ADDR_W:0] num_words;
  logic            abort;
  logic            busy;
  logic            done;
  logic [ADDR_W:0] word_count;

  imem_loader_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_words  (num_words),
    .abort      (abort),
    .bus        (bus.slave),
    .busy       (busy),
    .done       (done),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_wr   = 0;
  int n_done = 0;
  int n_busy = 0;
  int last_acc;
  logic [ADDR_W-1:0] wr_addr [256];
  logic [WORD_W-1:0] wr_data [256];
  int                wr_cyc  [256];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.we && n_wr < 256) begin
      wr_addr[n_wr] <= bus.waddr;
      wr_data[n_wr] <= bus.wdata;
      wr_cyc[n_wr]  <= cyc;
      n_wr          <= n_wr + 1;
    end
    if (done) n_done <= n_done + 1;
    if (busy) n_busy <= n_busy + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int g = 0;
    bus.byte_data  = b;
    bus.byte_valid = 1'b1;
    while (!bus.byte_ready && g < 50) begin
      tick(1);
      g++;
    end
    if (!bus.byte_ready) chk("ready_timeout", 0, 1);
    tick(1);
    last_acc = cyc;
    if (gap) begin
      bus.byte_valid = 1'b0;
      tick(1);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8], gap);
  endtask

  task automatic start_load(input int n);
    start     = 1'b1;
    num_words = (ADDR_W+1)'(n);
    tick(1);
    start     = 1'b0;
  endtask

  task automatic wait_done();
    int g = 0;
    bus.byte_valid = 1'b0;
    while (!done && g < 400) begin
      tick(1);
      g++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  function automatic logic [31:0] big_word(input int i);
    logic [7:0] k;
    k = 8'(i);
    return {k, 8'h5A, k ^ 8'h3C, 8'hFF - k};
  endfunction

  int base, dbase, bbase, acc0;

  initial begin
    rst = 1'b1; start = 1'b0; num_words = '0; abort = 1'b0;
    bus.byte_valid = 1'b0; bus.byte_data = 8'h00;

    // reset held three cycles, then idle with no stimulus
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("reset_outputs", {bus.we, busy, done, bus.byte_ready, word_count}, '0);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("idle_outputs", {bus.we, busy, done, bus.byte_ready, word_count}, '0);
    end

    // two-word load, back-to-back bytes
    base = n_wr; dbase = n_done;
    start_load(2);
    chk("busy_after_start", busy, 1);
    chk("ready_after_start", bus.byte_ready, 1);
    send_word(32'h20080005, 1'b0);
    acc0 = last_acc;
    chk("write_at_4th_byte", bus.we, 1);
    send_word(32'h8C090004, 1'b0);
    wait_done();
    chk("two_n_writes", n_wr - base, 2);
    chk("two_addr0", wr_addr[base], 0);
    chk("two_data0", wr_data[base], 32'h20080005);
    chk("two_lat0", wr_cyc[base], acc0);
    chk("two_addr1", wr_addr[base+1], 1);
    chk("two_data1", wr_data[base+1], 32'h8C090004);
    chk("two_lat1", wr_cyc[base+1], last_acc);
    chk("two_done_lat", cyc, wr_cyc[base+1] + 1);
    chk("two_word_count", word_count, 2);
    chk("two_busy_at_done", busy, 0);
    tick(1);
    chk("two_done_one_cycle", done, 0);
    chk("two_done_count", n_done - dbase, 1);

    // zero-length load
    tick(2);
    base = n_wr; dbase = n_done; bbase = n_busy;
    start_load(0);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    tick(1);
    chk("zero_done_drop", done, 0);
    tick(3);
    chk("zero_no_write", n_wr - base, 0);
    chk("zero_busy_never", n_busy - bbase, 0);
    chk("zero_done_count", n_done - dbase, 1);

    // oversize load clamps to 64 words
    base = n_wr; dbase = n_done;
    start_load(100);
    for (int i = 0; i < 64; i++) send_word(big_word(i), 1'b0);
    wait_done();
    chk("big_n_writes", n_wr - base, 64);
    for (int i = 0; i < 64; i++) begin
      chk("big_addr", wr_addr[base+i], i);
      chk("big_data", wr_data[base+i], big_word(i));
    end
    chk("big_word_count", word_count, 64);
    tick(1);
    chk("big_done_count", n_done - dbase, 1);

    // abort after one word plus two bytes, then a normal reload
    base = n_wr; dbase = n_done;
    start_load(3);
    send_word(32'h11223344, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    bus.byte_valid = 1'b0;
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("abort_busy_drop", busy, 0);
    chk("abort_ready_drop", bus.byte_ready, 0);
    tick(5);
    chk("abort_n_writes", n_wr - base, 1);
    chk("abort_addr0", wr_addr[base], 0);
    chk("abort_data0", wr_data[base], 32'h11223344);
    chk("abort_no_done", n_done - dbase, 0);
    chk("abort_word_count", word_count, 1);
    base = n_wr;
    start_load(1);
    send_word(32'hCAFEF00D, 1'b0);
    wait_done();
    chk("reload_n_writes", n_wr - base, 1);
    chk("reload_addr", wr_addr[base], 0);
    chk("reload_data", wr_data[base], 32'hCAFEF00D);
    chk("reload_word_count", word_count, 1);
    tick(2);

    // abort during the write cycle still lets the write complete
    base = n_wr; dbase = n_done;
    start_load(2);
    send_word(32'hDEADBEEF, 1'b0);
    chk("wabort_we", bus.we, 1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("wabort_busy", busy, 0);
    tick(3);
    chk("wabort_n_writes", n_wr - base, 1);
    chk("wabort_data", wr_data[base], 32'hDEADBEEF);
    chk("wabort_word_count", word_count, 1);
    chk("wabort_no_done", n_done - dbase, 0);

    // abort together with the fourth byte discards the word
    base = n_wr; dbase = n_done;
    start_load(1);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    bus.byte_data = 8'h04;
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    bus.byte_valid = 1'b0;
    chk("sabort_busy", busy, 0);
    tick(3);
    chk("sabort_no_write", n_wr - base, 0);
    chk("sabort_no_done", n_done - dbase, 0);

    // throttled stream with a start pulse mid-load
    base = n_wr; dbase = n_done;
    start_load(2);
    send_word(32'h20080005, 1'b1);
    start = 1'b1; num_words = 7'd5;
    tick(1);
    start = 1'b0;
    send_word(32'h8C090004, 1'b1);
    wait_done();
    chk("thr_n_writes", n_wr - base, 2);
    chk("thr_addr0", wr_addr[base], 0);
    chk("thr_data0", wr_data[base], 32'h20080005);
    chk("thr_addr1", wr_addr[base+1], 1);
    chk("thr_data1", wr_data[base+1], 32'h8C090004);
    chk("thr_word_count", word_count, 2);
    tick(3);
    chk("thr_no_restart", busy, 0);
    chk("thr_done_count", n_done - dbase, 1);

    // byte_valid while idle is not consumed
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("idle_ready_low", bus.byte_ready, 0);
    end
    bus.byte_valid = 1'b0;
    base = n_wr;
    start_load(1);
    send_word(32'h01020304, 1'b0);
    wait_done();
    chk("idle_n_writes", n_wr - base, 1);
    chk("idle_data", wr_data[base], 32'h01020304);
    tick(2);

    // reset in the middle of a word
    base = n_wr;
    start_load(1);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    bus.byte_valid = 1'b0;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ready", bus.byte_ready, 0);
    chk("rst_mid_we", bus.we, 0);
    chk("rst_mid_word_count", word_count, 0);
    tick(10);
    chk("rst_mid_no_write", n_wr - base, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
